// File: rtl/inst_encoder.sv
// Instruction encoder/emitter: packs symbolic requests into 32-bit words and
// writes them sequentially into IM, expanding LI into up to three words.
module inst_encoder #(
  parameter int IM_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_op,
  input  logic [4:0]           req_rt,
  input  logic [4:0]           req_ra,
  input  logic [4:0]           req_rb,
  input  logic [31:0]          req_imm,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 err_o,
  output logic [IM_ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT1, S_EMIT2} state_t;

  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_XORI = 6'b101011;
  localparam logic [5:0] OP_LWI  = 6'b000010;
  localparam logic [5:0] OP_SWI  = 6'b001010;
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_MEM  = 6'b011100;
  localparam logic [5:0] OP_BR   = 6'b100110;
  localparam logic [5:0] OP_BRZ  = 6'b100111;
  localparam logic [5:0] OP_J    = 6'b100100;

  localparam logic [IM_ADDR_W+1:0] CAP   = {2'b01, {IM_ADDR_W{1'b0}}};
  localparam logic [IM_ADDR_W-1:0] A_ONE = 1;

  state_t                state_q, state_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [IM_ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, w1_q, w1_d, w2_q, w2_d;
  logic [IM_ADDR_W:0]    cnt_q, cnt_d;

  logic [31:0]           w0, w1, w2;
  logic [1:0]            k;
  logic                  bad, over;
  logic [IM_ADDR_W+1:0]  need;
  logic                  fit_s14, fit_s15, fit_s16, fit_s20, fit_s24, fit_u5, fit_u15;

  // Signed N-bit fit: bits [31:N-1] all equal the sign bit.
  assign fit_s14 = (&req_imm[31:13]) | ~(|req_imm[31:13]);
  assign fit_s15 = (&req_imm[31:14]) | ~(|req_imm[31:14]);
  assign fit_s16 = (&req_imm[31:15]) | ~(|req_imm[31:15]);
  assign fit_s20 = (&req_imm[31:19]) | ~(|req_imm[31:19]);
  assign fit_s24 = (&req_imm[31:23]) | ~(|req_imm[31:23]);
  assign fit_u5  = ~(|req_imm[31:5]);
  assign fit_u15 = ~(|req_imm[31:15]);

  always_comb begin
    w0  = 32'h0;
    w1  = 32'h0;
    w2  = 32'h0;
    k   = 2'd1;
    bad = 1'b0;
    case (req_op)
      5'd0:  w0 = 32'h4000_0009;
      5'd1:  w0 = {1'b0, OP_ALU, req_rt, req_ra, req_rb, 5'b0, 5'b00000};
      5'd2:  w0 = {1'b0, OP_ALU, req_rt, req_ra, req_rb, 5'b0, 5'b00001};
      5'd3:  w0 = {1'b0, OP_ALU, req_rt, req_ra, req_rb, 5'b0, 5'b00010};
      5'd4:  w0 = {1'b0, OP_ALU, req_rt, req_ra, req_rb, 5'b0, 5'b00100};
      5'd5:  w0 = {1'b0, OP_ALU, req_rt, req_ra, req_rb, 5'b0, 5'b00011};
      5'd6:  begin w0 = {1'b0, OP_ALU, req_rt, req_ra, req_imm[4:0], 5'b0, 5'b01000}; bad = ~fit_u5; end
      5'd7:  begin w0 = {1'b0, OP_ALU, req_rt, req_ra, req_imm[4:0], 5'b0, 5'b01001}; bad = ~fit_u5; end
      5'd8:  begin w0 = {1'b0, OP_ALU, req_rt, req_ra, req_imm[4:0], 5'b0, 5'b01011}; bad = ~fit_u5; end
      5'd9:  begin w0 = {1'b0, OP_ADDI, req_rt, req_ra, req_imm[14:0]}; bad = ~fit_s15; end
      5'd10: begin w0 = {1'b0, OP_ORI,  req_rt, req_ra, req_imm[14:0]}; bad = ~fit_u15; end
      5'd11: begin w0 = {1'b0, OP_XORI, req_rt, req_ra, req_imm[14:0]}; bad = ~fit_u15; end
      5'd12: begin w0 = {1'b0, OP_MOVI, req_rt, req_imm[19:0]}; bad = ~fit_s20; end
      5'd13: begin w0 = {1'b0, OP_LWI,  req_rt, req_ra, req_imm[14:0]}; bad = ~fit_u15; end
      5'd14: begin w0 = {1'b0, OP_SWI,  req_rt, req_ra, req_imm[14:0]}; bad = ~fit_u15; end
      5'd15: w0 = {1'b0, OP_MEM, req_rt, req_ra, req_rb, 2'b00, 8'h02};
      5'd16: w0 = {1'b0, OP_MEM, req_rt, req_ra, req_rb, 2'b00, 8'h0A};
      5'd17: begin w0 = {1'b0, OP_BR, req_rt, req_ra, 1'b0, req_imm[13:0]}; bad = ~fit_s14; end
      5'd18: begin w0 = {1'b0, OP_BR, req_rt, req_ra, 1'b1, req_imm[13:0]}; bad = ~fit_s14; end
      5'd19: begin w0 = {1'b0, OP_BRZ, req_rt, 4'b0010, req_imm[15:0]}; bad = ~fit_s16; end
      5'd20: begin w0 = {1'b0, OP_BRZ, req_rt, 4'b0011, req_imm[15:0]}; bad = ~fit_s16; end
      5'd21: begin w0 = {1'b0, OP_J, 1'b0, req_imm[23:0]}; bad = ~fit_s24; end
      5'd22: begin
        if (fit_s20) begin
          w0 = {1'b0, OP_MOVI, req_rt, req_imm[19:0]};
        end else begin
          // MOVI hi20; SLLI 12; ORI lo12
          k  = 2'd3;
          w0 = {1'b0, OP_MOVI, req_rt, req_imm[31:12]};
          w1 = {1'b0, OP_ALU, req_rt, req_rt, 5'd12, 5'b0, 5'b01000};
          w2 = {1'b0, OP_ORI, req_rt, req_rt, 3'b000, req_imm[11:0]};
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign need = {1'b0, cnt_q} + {{IM_ADDR_W{1'b0}}, k};
  assign over = (need > CAP);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (bad || over) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = cnt_q[IM_ADDR_W-1:0];
            wdata_d = w0;
            cnt_d   = cnt_q + {{(IM_ADDR_W-1){1'b0}}, k};
            if (k == 2'd3) begin
              state_d = S_EMIT1;
              w1_d    = w1;
              w2_d    = w2;
            end
          end
        end
      end
      S_EMIT1: begin
        we_d    = 1'b1;
        addr_d  = addr_q + A_ONE;
        wdata_d = w1_q;
        state_d = S_EMIT2;
      end
      S_EMIT2: begin
        we_d    = 1'b1;
        addr_d  = addr_q + A_ONE;
        wdata_d = w2_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign err_o     = err_q;
  assign word_cnt  = cnt_q;

endmodule
